// File: rtl/fp_wb_arbiter_pkg.sv
// Shared processor package: FP register file geometry and the default number
// of FP writeback requesters.
//   FP_ADDR_W     : FP register address width
//   FP_DATA_W     : FP register data width
//   FP_WB_NUM_REQ : default number of writeback requesters
package fp_wb_arbiter_pkg;

    localparam int FP_ADDR_W     = 5;
    localparam int FP_DATA_W     = 32;
    localparam int FP_WB_NUM_REQ = 4;

    typedef logic [FP_ADDR_W-1:0] fp_addr_t;
    typedef logic [FP_DATA_W-1:0] fp_data_t;

    // f0 is hardwired; writes to it are accepted and dropped.
    function automatic logic fp_is_f0(input fp_addr_t addr);
        return (addr == '0);
    endfunction

endpackage

// File: rtl/fp_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
// Searches upward from ptr (wrapping) for the first asserted request.
//   req       : request vector
//   ptr       : index with highest priority this cycle (must be < N)
//   gnt       : one-hot grant (all zero when no request)
//   gnt_valid : some request was granted
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid
);

    logic [N-1:0] mask_hi;
    logic [N-1:0] req_hi;
    logic [N-1:0] sel;

    // Requests at or above ptr take precedence; if none exist the search
    // wraps, which is the same as taking the lowest request overall.
    always_comb begin
        mask_hi = '0;
        for (int i = 0; i < N; i++) begin
            mask_hi[i] = (i >= int'(ptr));
        end
        req_hi = req & mask_hi;
        sel    = (|req_hi) ? req_hi : req;
        gnt    = '0;
        // Descending scan so the lowest set bit of sel is the one kept.
        for (int i = N - 1; i >= 0; i--) begin
            if (sel[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
        gnt_valid = |req;
    end

endmodule

// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter: merges NUM_REQ FP writeback requesters onto the single FP
// register file write port, one write per cycle, round-robin fair.
//   clk, rst_n      : clock, synchronous active-low reset
//   req_valid/addr/data : per-requester writeback request
//   req_ready       : per-requester accept (combinational)
//   wr_enable/addr/data : registered register-file write port
//   grant_idx       : requester whose write is on wr_* (valid with wr_enable)
// Requests to f0 are accepted at once and never occupy the write port.
module fp_wb_arbiter
    import fp_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = FP_WB_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][FP_ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][FP_DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                wr_enable,
    output logic [FP_ADDR_W-1:0]                wr_addr,
    output logic [FP_DATA_W-1:0]                wr_data,
    output logic [IDX_W-1:0]                    grant_idx
);

    logic [IDX_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]   rr_req;
    logic [NUM_REQ-1:0]   gnt;
    logic                 gnt_valid;
    logic [IDX_W-1:0]     sel_idx;
    fp_addr_t             sel_addr;
    fp_data_t             sel_data;
    logic [IDX_W-1:0]     ptr_next;

    // Only non-f0 requests compete for the write port; reset masks everything.
    always_comb begin
        rr_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_req[i] = rst_n & req_valid[i] & ~fp_is_f0(req_addr[i]);
        end
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (IDX_W)
    ) u_rr_arbiter (
        .req       (rr_req),
        .ptr       (rr_ptr),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = rst_n & req_valid[i] & (fp_is_f0(req_addr[i]) | gnt[i]);
        end
    end

    always_comb begin
        sel_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_idx  = IDX_W'(i);
                sel_addr = req_addr[i];
                sel_data = req_data[i];
            end
        end
        // NUM_REQ need not be a power of two, so wrap explicitly.
        ptr_next = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_enable <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            wr_enable <= gnt_valid;
            if (gnt_valid) begin
                wr_addr   <= sel_addr;
                wr_data   <= sel_data;
                grant_idx <= sel_idx;
                rr_ptr    <= ptr_next;
            end
        end
    end

endmodule

// File: doc/fp_wb_arbiter.md
FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

Interface
REQ-001 SHALL have parameter: NUM_REQ, default 4, number of FP writeback requesters (2..8).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: req_valid  input  NUM_REQ  per-requester writeback request.
REQ-005 SHALL have port: req_addr  input  NUM_REQ x 5  destination FP register per requester.
REQ-006 SHALL have port: req_data  input  NUM_REQ x 32  result data per requester.
REQ-007 SHALL have port: req_ready  output  NUM_REQ  per-requester accept; a transfer occurs when valid and ready are both high at a clock edge.
REQ-008 SHALL have port: wr_enable  output  1  drives the FP register file write enable.
REQ-009 SHALL have port: wr_addr  output  5  drives the FP register file write address.
REQ-010 SHALL have port: wr_data  output  32  drives the FP register file write data.
REQ-011 SHALL have port: grant_idx  output  clog2(NUM_REQ)  index of the requester whose write is on wr_* this cycle (valid only with wr_enable).

Function
REQ-012 SHALL grant at most one requester with req_addr != 0 per cycle, chosen round-robin starting at rr_ptr and searching upward with wrap.
REQ-013 SHALL update rr_ptr to (granted index + 1) mod NUM_REQ on each grant; rr_ptr unchanged when nothing is granted.
REQ-014 SHALL register the granted addr/data: wr_enable/wr_addr/wr_data/grant_idx appear exactly one cycle after the accepting edge, for exactly one cycle per transfer.
REQ-015 SHALL deassert wr_enable in any cycle following an edge with no non-f0 grant; wr_addr/wr_data then hold their previous values.
REQ-016 SHALL accept requests with req_addr == 0 (f0) immediately (req_ready high in the same cycle as req_valid), in parallel with the normal grant, without using the write port or moving rr_ptr.
REQ-017 SHALL drive req_ready combinationally; req_ready[i] may depend on req_valid but SHALL NOT be high while req_valid[i] is low.
REQ-018 Requesters SHALL hold valid, addr and data stable until accepted; the arbiter SHALL NOT depend on a requester dropping valid.
REQ-019 SHALL guarantee any continuously valid requester is granted within NUM_REQ cycles (no starvation).
REQ-020 SHALL treat two requesters targeting the same register in the same cycle as independent requests: each is written in grant order, and the later-granted write wins.
REQ-021 SHALL sustain one register write per cycle under continuous requests (full throughput, no bubbles).

Reset
REQ-022 While rst_n is low at a clock edge: wr_enable=0, wr_addr=0, wr_data=0, grant_idx=0, rr_ptr=0.
REQ-023 While rst_n is low: req_ready SHALL be all zero; no request is accepted.
REQ-024 Reset asserted mid-operation SHALL discard the registered write: no wr_enable in the cycle after a reset edge.

Structure
REQ-025 SHALL place FP register-address width (5), data width (32) and the default NUM_REQ in the shared processor package.
REQ-026 SHALL implement the round-robin selection as one sub-module rr_arbiter (inputs request vector and pointer; outputs one-hot grant and valid), reused elsewhere in the core.
REQ-027 The datapath register (wr_* stage) and rr_ptr SHALL be the only state in the block.

Verification
REQ-028 Reset then single request: req_valid=0001, addr=3, data=0x3F800000 -> req_ready=0001 same cycle; next cycle wr_enable=1, wr_addr=3, wr_data=0x3F800000, grant_idx=0.
REQ-029 All four valid continuously, addrs 1..4 -> grants in order 0,1,2,3,0,... ; wr_enable high every cycle from the cycle after the first grant.
REQ-030 req0 addr=0 and req2 addr=7 valid together -> req_ready=0101 same cycle; next cycle one write, wr_addr=7; rr_ptr=3.
REQ-031 req1 and req3 both target addr=5 with data 0xA and 0xB, rr_ptr=0 -> writes 0xA then 0xB on consecutive cycles; final register value 0xB.
REQ-032 Grant occurs, rst_n driven low at the next edge -> no wr_enable after that edge; all outputs zero; first grant after reset goes to the lowest valid index.
REQ-033 req3 held valid while req0..2 are continuously valid -> req3 granted within 4 cycles of asserting valid.
